// File: rtl/result_fifo_pkg.sv
// rtl/result_fifo_pkg.sv - shared widths, depth and result type for the result collector
package result_fifo_pkg;

  localparam int RESULT_W          = 4;
  localparam int RESULT_FIFO_DEPTH = 4;
  localparam int DROPCNT_W         = 8;

  typedef logic [RESULT_W-1:0] result_t;

endpackage

// File: rtl/result_fifo_if.sv
// rtl/result_fifo_if.sv - valid/ready result stream between the collector and its consumer
interface result_fifo_if
  import result_fifo_pkg::*;
#(
  parameter int DATA_W = RESULT_W
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  // Collector side: offers the head entry, sees the consumer's accept.
  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  // Consumer side: sees the head entry, drives the accept.
  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/result_fifo_mem.sv
// rtl/result_fifo_mem.sv - reset-cleared register array, one sync write port, one async read port
module result_fifo_mem
  import result_fifo_pkg::*;
#(
  parameter int DEPTH  = RESULT_FIFO_DEPTH,
  parameter int DATA_W = RESULT_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset so the head reads as zero when nothing is queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - outr capture FIFO with sticky overflow; RESULT_FIFO_DROPCNT_EN adds drop_cnt
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter int DEPTH  = RESULT_FIFO_DEPTH,
  parameter int DATA_W = RESULT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ld_outr,
  input  logic [DATA_W-1:0]              outr,
  result_fifo_if.master                  m,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           overflow,
  input  logic                           clr_ovf
`ifdef RESULT_FIFO_DROPCNT_EN
  ,
  output logic [DROPCNT_W-1:0]           drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic              ld_d;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] head_data;

  // Status is decoded from registered occupancy only, so it never glitches.
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;

  assign m.m_valid = !empty;
  assign m.m_data  = head_data;

  // A push into a full queue is still accepted when the head leaves on the same edge.
  assign pop  = m.m_valid && m.m_ready;
  assign push = ld_d && (!full || pop);
  assign drop = ld_d && full && !pop;

  // outr only holds the new value one edge after LD_outr, so delay the strobe to match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_d <= 1'b0;
    end else begin
      ld_d <= ld_outr;
    end
  end

  // Read and write pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy is kept apart from the pointers so full and empty never alias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  result_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (outr),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

`ifdef RESULT_FIFO_DROPCNT_EN
  logic [DROPCNT_W-1:0] drop_q;

  assign drop_cnt = drop_q;

  // Saturating drop counter; a drop alongside a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (drop) begin
      if (clr_ovf) begin
        drop_q <= DROPCNT_W'(1);
      end else if (drop_q != {DROPCNT_W{1'b1}}) begin
        drop_q <= drop_q + DROPCNT_W'(1);
      end
    end else if (clr_ovf) begin
      drop_q <= '0;
    end
  end
`else
  // Without the drop counter only the sticky overflow flag reports lost results.
`endif

endmodule

// File: tb/tb_result_fifo.sv
// tb/tb_result_fifo.sv - directed table and sequence bench for result_fifo
module tb_result_fifo;
  import result_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld_outr = 1'b0;
  logic [3:0] outr = 4'h0;
  logic       clr_ovf = 1'b0;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
`ifdef RESULT_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  result_fifo_if #(.DATA_W(4)) mif ();

  result_fifo #(.DEPTH(4), .DATA_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_outr  (ld_outr),
    .outr     (outr),
    .m        (mif),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
`ifdef RESULT_FIFO_DROPCNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic       ld;
    logic [3:0] d;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [3:0] dat;
    logic [2:0] cnt;
    logic       ovf;
    logic [7:0] drp;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic ld, input logic [3:0] d, input logic rdy,
                              input logic clr, input logic v, input logic [3:0] dat,
                              input logic [2:0] cnt, input logic ovf, input logic [7:0] drp);
    vec_t r;
    r.ld = ld; r.d = d; r.rdy = rdy; r.clr = clr;
    r.v = v; r.dat = dat; r.cnt = cnt; r.ovf = ovf; r.drp = drp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic [3:0] d, input logic rdy, input logic clr);
    ld_outr     = ld;
    outr        = d;
    mif.m_ready = rdy;
    clr_ovf     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ld, d, rdy, clr | valid, data, count, overflow, drop_cnt
    tbl[0]  = mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);
    tbl[1]  = mk(1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 4'hA, 3'd1, 1'b0, 8'd0);
    tbl[2]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);
    tbl[3]  = mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);
    tbl[4]  = mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 4'h1, 3'd1, 1'b0, 8'd0);
    tbl[5]  = mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 4'h1, 3'd2, 1'b0, 8'd0);
    tbl[6]  = mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 4'h1, 3'd3, 1'b0, 8'd0);
    tbl[7]  = mk(1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 4'h1, 3'd4, 1'b0, 8'd0);
    tbl[8]  = mk(1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'h1, 3'd4, 1'b1, 8'd1);
    tbl[9]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 3'd3, 1'b1, 8'd1);
    tbl[10] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3, 3'd2, 1'b1, 8'd1);
    tbl[11] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4, 3'd1, 1'b1, 8'd1);
    tbl[12] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 8'd1);
    tbl[13] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);
    tbl[14] = mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);
    tbl[15] = mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 4'h1, 3'd1, 1'b0, 8'd0);
    tbl[16] = mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 4'h1, 3'd2, 1'b0, 8'd0);
    tbl[17] = mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 4'h1, 3'd3, 1'b0, 8'd0);
    tbl[18] = mk(1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 4'h1, 3'd4, 1'b0, 8'd0);
    tbl[19] = mk(1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 4'h2, 3'd4, 1'b0, 8'd0);
    tbl[20] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3, 3'd3, 1'b0, 8'd0);
    tbl[21] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4, 3'd2, 1'b0, 8'd0);
    tbl[22] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h6, 3'd1, 1'b0, 8'd0);
    tbl[23] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);
    tbl[24] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);
    tbl[25] = mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);
    tbl[26] = mk(1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 4'h9, 3'd1, 1'b0, 8'd0);
    tbl[27] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 8'd0);

    mif.m_ready = 1'b0;

    // Reset state
    #12;
    chk("rst.valid", 32'(mif.m_valid), 32'd0);
    chk("rst.data", 32'(mif.m_data), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.ovf", 32'(overflow), 32'd0);
`ifdef RESULT_FIFO_DROPCNT_EN
    chk("rst.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table: single capture, fill/overflow/drain, push+pop while full, ready while empty
    for (int i = 0; i < 28; i++) begin
      step(tbl[i].ld, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("v%0d.valid", i), 32'(mif.m_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("v%0d.data", i), 32'(mif.m_data), 32'(tbl[i].dat));
      end
      chk($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d.full", i), 32'(full), 32'(tbl[i].cnt == 3'd4));
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(tbl[i].cnt == 3'd0));
      chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(tbl[i].ovf));
`ifdef RESULT_FIFO_DROPCNT_EN
      chk($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].drp));
`endif
    end

    // Drop and clear on the same edge: set wins, counter restarts at one
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    chk("sw.full", 32'(full), 32'd1);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    chk("sw.ovf_first", 32'(overflow), 32'd1);
    step(1'b0, 4'h5, 1'b0, 1'b1);
    chk("sw.ovf_setwins", 32'(overflow), 32'd1);
    chk("sw.count", 32'(count), 32'd4);
    chk("sw.head", 32'(mif.m_data), 32'd1);
`ifdef RESULT_FIFO_DROPCNT_EN
    chk("sw.drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("sw.ovf_clr", 32'(overflow), 32'd0);
`ifdef RESULT_FIFO_DROPCNT_EN
    chk("sw.drop_clr", 32'(drop_cnt), 32'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sw.drain%0d", k), 32'(mif.m_data), 32'(k + 1));
      step(1'b0, 4'h0, 1'b1, 1'b0);
    end
    chk("sw.empty", 32'(empty), 32'd1);

    // Backpressure: head 7 held for five cycles while two more captures land
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    chk("bp.hold0", 32'(mif.m_data), 32'h7);
    step(1'b1, 4'h8, 1'b0, 1'b0);
    chk("bp.hold1", 32'(mif.m_data), 32'h7);
    step(1'b0, 4'h9, 1'b0, 1'b0);
    chk("bp.hold2", 32'(mif.m_data), 32'h7);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("bp.hold3", 32'(mif.m_data), 32'h7);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("bp.hold4", 32'(mif.m_data), 32'h7);
    chk("bp.count", 32'(count), 32'd3);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("bp.next8", 32'(mif.m_data), 32'h8);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("bp.next9", 32'(mif.m_data), 32'h9);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("bp.empty", 32'(empty), 32'd1);

    // Wrap-around: ten capture/drain pairs
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'h0, 1'b0, 1'b0);
      step(1'b0, 4'(k), 1'b0, 1'b0);
      chk($sformatf("wr%0d.data", k), 32'(mif.m_data), 32'(k));
      chk($sformatf("wr%0d.count", k), 32'(count), 32'd1);
      step(1'b0, 4'h0, 1'b1, 1'b0);
      chk($sformatf("wr%0d.empty", k), 32'(empty), 32'd1);
    end

    // Async reset between the ld_outr sample and its push edge
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    chk("ar.pre_count", 32'(count), 32'd1);
    ld_outr = 1'b0;
    outr    = 4'h5;
    rst     = 1'b0;
    #1;
    chk("ar.empty", 32'(empty), 32'd1);
    chk("ar.valid", 32'(mif.m_valid), 32'd0);
    chk("ar.count", 32'(count), 32'd0);
    chk("ar.data", 32'(mif.m_data), 32'd0);
    #2;
    rst = 1'b1;
    step(1'b0, 4'h5, 1'b0, 1'b0);
    chk("ar.nopush_empty", 32'(empty), 32'd1);
    chk("ar.nopush_count", 32'(count), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("ar.ovf", 32'(overflow), 32'd0);
    chk("ar.final_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/result_fifo.md
# result_fifo

Downstream result collector for the accumulator CPU datapath. Captures each new value of the 4-bit output register `outr` when the control unit's `LD_outr` strobe fires and queues it in a small FIFO. It presents queued results to an external consumer through a valid/ready handshake. Overflow is flagged, never silently absorbed.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `DATA_W`, default 4: result width; matches `outr`.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `ld_outr`, input, 1: copy of control-unit `LD_outr`.
- `outr`, input, DATA_W: datapath output register.
- `m_valid`, output, 1: head entry available.
- `m_data`, output, DATA_W: head entry value.
- `m_ready`, input, 1: consumer accepts head.
- `count`, output, $clog2(DEPTH+1): occupied entries.
- `full`, output, 1: count == DEPTH.
- `empty`, output, 1: count == 0.
- `overflow`, output, 1: sticky; a result was dropped.
- `clr_ovf`, input, 1: clears `overflow`.
- `drop_cnt`, output, 8: present only with `RESULT_FIFO_DROPCNT_EN`.

## Operation
- Capture alignment: `outr` loads on the same edge that samples `LD_outr`. The block therefore registers `ld_outr` into `ld_d` and pushes `outr` on the next edge where `ld_d`=1.
- Push: when `ld_d`=1 and the FIFO is not full, write `outr` at `wr_ptr`, then advance `wr_ptr` modulo DEPTH.
- Pop: when `m_valid`=1 and `m_ready`=1, advance `rd_ptr` modulo DEPTH.
- `m_valid` = !`empty`.
- `m_data` = mem[`rd_ptr`]. It is held stable while `m_valid`=1 and `m_ready`=0.
- Push while full with no pop: the value is dropped and `overflow` is set. Stored data and `count` are unchanged.
- Push and pop in the same cycle while full: both are accepted and `count` stays at DEPTH. No overflow.
- Push and pop in the same cycle while not empty: `count` is unchanged.
- Push while empty: the entry becomes visible the next cycle. There is no fall-through.
- `m_ready`=1 while empty: ignored, with no pointer movement.
- `clr_ovf` clears `overflow` on the next edge. If a drop occurs in the same cycle, set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is tracked separately, so full and empty are unambiguous.

## Timing
- Reset (`rst`=0, asynchronous):
  - `ld_d`, pointers, `count`, `overflow` and `drop_cnt` go to 0.
  - `m_valid`=0, `full`=0, `empty`=1, `m_data`=0 (memory cleared).
- Reset mid-operation: all queued and pending captures are discarded. A `ld_outr` sampled before reset is lost.
- Latency: `ld_outr` sampled at edge N → push at edge N+1 → `m_valid`=1 after N+1.
- Throughput: one push and one pop per cycle.
- `full`, `empty`, `count` and `overflow` are registered-state decodes. They are glitch-free and valid the cycle after the causing edge.

## Configuration
- `RESULT_FIFO_DROPCNT_EN` defined:
  - Adds an 8-bit `drop_cnt` output.
  - It increments on every dropped push and saturates at 255.
  - It is cleared by `clr_ovf` (an increment in the same cycle wins and yields 1).
- Not defined: no `drop_cnt` port and no counter logic. `overflow` behaviour is identical.

## Structure
- `result_fifo_pkg` holds:
  - `RESULT_W` = 4
  - `RESULT_FIFO_DEPTH` = 4
  - `DROPCNT_W` = 8
  - typedef `result_t` (logic [RESULT_W-1:0])
- One sub-module, `result_fifo_mem`: DEPTH×DATA_W register array, one synchronous write port, one asynchronous read port, reset-cleared.
- Pointers, count, overflow, capture alignment and handshake stay in `result_fifo`.

## Test plan
- Reset, then single capture:
  - `ld_outr` pulse with `outr`=4'hA → `m_valid` rises 2 cycles later, `m_data`=4'hA, `count`=1.
  - `m_ready`=1 for one cycle → `empty`=1.
- Fill and overflow (DEPTH=4, `m_ready`=0):
  - 5 captures of 1,2,3,4,5 → `full`=1, `overflow`=1, `drop_cnt`=1 (macro on).
  - Drain yields 1,2,3,4.
- Simultaneous push/pop while full:
  - Full with 1..4, then capture 6 with `m_ready`=1 → `count` stays 4, `overflow` stays 0.
  - Drain yields 2,3,4,6.
- Backpressure stability: head=4'h7 with `m_ready`=0 for 5 cycles while 2 more captures arrive → `m_data` stays 4'h7 throughout.
- Wrap-around: 10 capture/drain pairs with values 0..9 → output order 0..9, pointers wrap twice, `count` never exceeds 1.
- Async reset mid-stream:
  - Assert `rst`=0 between `ld_outr` and the push edge → `empty`=1 immediately and no push after release.
  - `clr_ovf` afterwards leaves `overflow`=0.
